// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  // Access size encodings as carried on in_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Stage controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // MEM/WB register contents consumed by wb_stage.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
  } wb_t;

  // Copy of the accepted memory op, held stable for the whole bus access.
  typedef struct packed {
    logic        we;
    logic        reg_write;
    logic        mem_to_reg;
    logic        is_unsigned;
    size_e       size;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } mem_req_t;

  // A bubble writes nothing back and carries no data.
  localparam wb_t      WB_BUBBLE = '0;
  localparam mem_req_t REQ_IDLE  = '0;

  // A memory op that must not reach the bus: conflicting direction,
  // reserved size, or an address not aligned to the access size.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = rd & wr;
    case (size)
      SZ_HALF: bad = bad | addr_lo[0];
      SZ_WORD: bad = bad | (|addr_lo);
      SZ_RSVD: bad = 1'b1;
      default: bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: request held until a one-cycle ack pulse.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  // The pipeline stage initiates accesses.
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  // The memory responds.
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // Lane selection by low address bits, then size-dependent shaping.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be        = '0;
    wdata     = '0;
    load_data = '0;
    lane      = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = lane;
      end
      default: begin
        be        = '0;
        wdata     = '0;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs loads/stores on the data bus, stalls
// upstream while an access is outstanding, registers the MEM/WB fields.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_dest_reg,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_dest_reg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic        misalign_err
);

  state_e   state_q, state_d;
  mem_req_t req_q, req_d;
  wb_t      wb_q, wb_d;
  logic     misalign_q, misalign_d;
  logic     stall_c;

  logic        mem_op;
  logic        illegal;
  logic        busy;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign mem_op  = in_valid & (in_mem_read | in_mem_write);
  assign illegal = is_illegal(in_mem_read, in_mem_write, size_e'(in_size), in_alu_result[1:0]);
  assign busy    = (state_q == ST_BUSY);

  // Lane steering always works from the latched copy so the bus stays stable.
  mem_lane_align u_align (
    .addr_lo     (req_q.alu_result[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .store_data  (req_q.store_data),
    .rdata       (dmem.dmem_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .load_data   (lane_load)
  );

  // Next-state, latch capture and MEM/WB next values.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wb_d       = WB_BUBBLE;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && illegal) begin
          misalign_d = 1'b1;
        end else if (mem_op) begin
          req_d.we          = in_mem_write;
          req_d.reg_write   = in_reg_write;
          req_d.mem_to_reg  = in_mem_to_reg;
          req_d.is_unsigned = in_unsigned;
          req_d.size        = size_e'(in_size);
          req_d.dest_reg    = in_dest_reg;
          req_d.alu_result  = in_alu_result;
          req_d.store_data  = in_store_data;
          state_d           = ST_BUSY;
          stall_c           = 1'b1;
        end else begin
          wb_d.reg_write  = in_valid & in_reg_write;
          wb_d.mem_to_reg = in_mem_to_reg;
          wb_d.dest_reg   = in_dest_reg;
          wb_d.alu_result = in_alu_result;
          wb_d.mem_data   = '0;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack) begin
          wb_d.reg_write  = req_q.reg_write;
          wb_d.mem_to_reg = req_q.mem_to_reg;
          wb_d.dest_reg   = req_q.dest_reg;
          wb_d.alu_result = req_q.alu_result;
          wb_d.mem_data   = req_q.we ? 32'h0 : lane_load;
          state_d         = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latched request, MEM/WB fields and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= REQ_IDLE;
      wb_q       <= WB_BUBBLE;
      misalign_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
    end
  end

  // Stall is combinational; held low while reset is asserted.
  assign stall = rst_n & stall_c;

  // Bus outputs are zero outside BUSY; write-only fields are zero for loads.
  assign dmem.dmem_req   = busy;
  assign dmem.dmem_we    = busy & req_q.we;
  assign dmem.dmem_addr  = busy ? {req_q.alu_result[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.dmem_be    = (busy & req_q.we) ? lane_be : 4'b0000;
  assign dmem.dmem_wdata = (busy & req_q.we) ? lane_wdata : 32'h0;

  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_dest_reg   = wb_q.dest_reg;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_mem_data   = wb_q.mem_data;
  assign misalign_err  = misalign_q;

endmodule
